// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word, RAM handshake state, arbiter FSM state and
// request source encoding, plus the per-core request priority helper.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arbstate_t;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_IREAD  = 2'd1,
        SRC_DREAD  = 2'd2,
        SRC_DWRITE = 2'd3
    } arbsrc_t;

    // Within one core a data write beats a data read, which beats an ifetch.
    function automatic arbsrc_t core_src(input logic iren, input logic dren, input logic dwen);
        if (dwen)      return SRC_DWRITE;
        else if (dren) return SRC_DREAD;
        else if (iren) return SRC_IREAD;
        return SRC_NONE;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between two cores.
// Fairness between cores is chosen by ARB_ROUND_ROBIN_EN (fixed core-0 priority when undefined).
module arb_pick
    import cpu_types_pkg::*;
(
    input  logic [1:0] iren,
    input  logic [1:0] dren,
    input  logic [1:0] dwen,
    input  logic       last,
    output logic       vld,
    output logic       core,
    output arbsrc_t    src
);

    logic    [1:0] req;
    arbsrc_t       src0;
    arbsrc_t       src1;

    assign req  = iren | dren | dwen;
    assign src0 = core_src(iren[0], dren[0], dwen[0]);
    assign src1 = core_src(iren[1], dren[1], dwen[1]);
    assign vld  = |req;

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie the core that was not served most recently wins.
    assign core = (&req) ? ~last : (req[1] & ~req[0]);
`else
    logic unused_last;
    assign unused_last = last;
    assign core = req[1] & ~req[0];
`endif

    assign src = core ? src1 : src0;

endmodule

// File: rtl/ram_arbiter.sv
// Two-core arbiter for a single RAM port: IDLE/GRANT FSM with per-core
// dWEN > dREN > iREN priority. Optional round-robin via ARB_ROUND_ROBIN_EN.
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [CPUS-1:0] iREN,
    input  logic [CPUS-1:0] dREN,
    input  logic [CPUS-1:0] dWEN,
    input  word_t           iaddr  [CPUS],
    input  word_t           daddr  [CPUS],
    input  word_t           dstore [CPUS],
    output logic [CPUS-1:0] iwait,
    output logic [CPUS-1:0] dwait,
    output word_t           iload  [CPUS],
    output word_t           dload  [CPUS],
    output word_t           ramaddr,
    output word_t           ramstore,
    output logic            ramREN,
    output logic            ramWEN,
    input  word_t           ramload,
    input  ramstate_t       ramstate
);

    arbstate_t state, next_state;
    logic      owner;
    arbsrc_t   src;
    logic      owner_req;
    logic      done;
    logic      last_served;
    logic      pick_vld;
    logic      pick_core;
    arbsrc_t   pick_src;

    arb_pick u_pick (
        .iren (iREN),
        .dren (dREN),
        .dwen (dWEN),
        .last (last_served),
        .vld  (pick_vld),
        .core (pick_core),
        .src  (pick_src)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            owner <= 1'b0;
            src   <= SRC_NONE;
        end else begin
            state <= next_state;
            if (state == IDLE && pick_vld) begin
                owner <= pick_core;
                src   <= pick_src;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_served <= 1'b1;
        end else if (done) begin
            last_served <= owner;
        end
    end
`else
    assign last_served = 1'b1;
`endif

    // Is the owner still holding the exact request it was granted for?
    always_comb begin
        owner_req = 1'b0;
        unique case (src)
            SRC_DWRITE: owner_req = dWEN[owner];
            SRC_DREAD:  owner_req = dREN[owner];
            SRC_IREAD:  owner_req = iREN[owner];
            default:    owner_req = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        ramaddr    = '0;
        ramstore   = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        iwait      = iREN;
        dwait      = dREN | dWEN;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_vld) next_state = GRANT;
            end
            GRANT: begin
                ramaddr  = (src == SRC_IREAD) ? iaddr[owner] : daddr[owner];
                ramstore = dstore[owner];
                if (!owner_req) begin
                    next_state = IDLE;
                end else begin
                    ramWEN = (src == SRC_DWRITE);
                    ramREN = (src != SRC_DWRITE);
                    if (ramstate == ACCESS) begin
                        done       = 1'b1;
                        next_state = IDLE;
                        if (src == SRC_IREAD) iwait[owner] = 1'b0;
                        else                  dwait[owner] = 1'b0;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        for (int n = 0; n < CPUS; n++) begin
            iload[n] = ramload;
            dload[n] = ramload;
        end
    end

endmodule
